// File: rtl/lpc_pkg.sv
// Shared definitions for the LPC synthesis filter: defaults, accumulator width, FSM states.
// The output reduction honours LPC_SYNTH_SAT_EN (saturate) and otherwise wraps to 16 bits.
package lpc_pkg;
  localparam int ORDER_DEF     = 10;
  localparam int COEF_FRAC_DEF = 12;
  localparam int ACC_W         = 40;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  function automatic logic signed [15:0] reduce16(input logic signed [ACC_W-1:0] v);
`ifdef LPC_SYNTH_SAT_EN
    if (v > ACC_W'(32767))       return 16'sh7fff;
    else if (v < ACC_W'(-32768)) return 16'sh8000;
    else                         return 16'(v);
`else
    return 16'(v);
`endif
  endfunction
endpackage

// File: rtl/lpc_hist_ring.sv
// Circular history of past outputs; rd_off=k returns the sample written k+1 writes ago.
module lpc_hist_ring #(
  parameter int DEPTH = 10,
  parameter int W     = 16,
  parameter int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                wr_en,
  input  logic signed [W-1:0] wr_data,
  input  logic [PW-1:0]       rd_off,
  output logic signed [W-1:0] rd_data
);
  logic signed [W-1:0] mem [DEPTH];
  logic [PW-1:0]       wp;
  logic [PW:0]         idx_raw;
  logic [PW-1:0]       idx;

  // Newest entry sits just behind the write pointer.
  always_comb begin
    idx_raw = {1'b0, wp} + (PW+1)'(DEPTH - 1) - {1'b0, rd_off};
    idx     = PW'((idx_raw >= (PW+1)'(DEPTH)) ? idx_raw - (PW+1)'(DEPTH) : idx_raw);
  end

  assign rd_data = mem[idx];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wp <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wp] <= wr_data;
      wp      <= (wp == PW'(DEPTH - 1)) ? '0 : wp + 1'b1;
    end
  end
endmodule

// File: rtl/lpc_synth.sv
// All-pole LPC synthesis filter y[n] = e[n] - sum a_k*y[n-k], one shared multiplier,
// ORDER+2 cycles per sample. Define LPC_SYNTH_SAT_EN to saturate instead of wrap.
module lpc_synth
  import lpc_pkg::*;
#(
  parameter int ORDER     = ORDER_DEF,
  parameter int COEF_FRAC = COEF_FRAC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        coef_wr,
  input  logic [3:0]  coef_addr,
  input  logic [15:0] coef_data,
  input  logic        coef_commit,
  input  logic        flush,
  input  logic [15:0] e_in,
  input  logic        e_valid,
  output logic        e_ready,
  output logic [15:0] y_out,
  output logic        y_valid
);
  localparam int KW = (ORDER > 1) ? $clog2(ORDER) : 1;

  state_t                  state, state_nx;
  logic [KW-1:0]           k;
  logic signed [15:0]      shadow [ORDER];
  logic signed [15:0]      active [ORDER];
  logic                    pend;
  logic signed [ACC_W-1:0] acc, rnd, sh, e_ext, prod_ext;
  logic signed [31:0]      prod;
  logic signed [15:0]      hist_rd, y_nx;
  logic                    accept, last_mac, hist_wr, do_flush, do_commit;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    hist_wr  = 1'b0;
    do_flush = 1'b0;
    last_mac = (k == KW'(ORDER - 1));
    unique case (state)
      ST_IDLE: begin
        do_flush = flush;
        if (e_valid) begin
          accept   = 1'b1;
          state_nx = ST_MAC;
        end
      end
      ST_MAC:  if (last_mac) state_nx = ST_OUT;
      ST_OUT: begin
        hist_wr  = 1'b1;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  assign e_ready = (state == ST_IDLE);

  // A commit seen mid-sample waits for the OUT->IDLE edge so one sample uses one bank.
  assign do_commit = ((state == ST_IDLE) && coef_commit) ||
                     ((state == ST_OUT) && (pend || coef_commit));

  assign e_ext    = {{(ACC_W-16){e_in[15]}}, e_in};
  assign prod     = active[k] * hist_rd;
  assign prod_ext = {{(ACC_W-32){prod[31]}}, prod};
  assign rnd      = acc + (ACC_W'(1) <<< (COEF_FRAC - 1));
  assign sh       = rnd >>> COEF_FRAC;
  assign y_nx     = reduce16(sh);

  lpc_hist_ring #(.DEPTH(ORDER), .W(16), .PW(KW)) u_ring (
    .clk     (clk),
    .rst     (rst),
    .flush   (do_flush),
    .wr_en   (hist_wr),
    .wr_data (y_nx),
    .rd_off  (k),
    .rd_data (hist_rd)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      k       <= '0;
      pend    <= 1'b0;
      y_out   <= '0;
      y_valid <= 1'b0;
      for (int i = 0; i < ORDER; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      y_valid <= 1'b0;
      if (coef_wr && (int'(coef_addr) < ORDER)) shadow[coef_addr] <= coef_data;
      if (do_commit)
        for (int i = 0; i < ORDER; i++) active[i] <= shadow[i];
      if (state == ST_OUT)                       pend <= 1'b0;
      else if (coef_commit && state != ST_IDLE)  pend <= 1'b1;
      if (accept) begin
        acc <= e_ext <<< COEF_FRAC;
        k   <= '0;
      end
      if (state == ST_MAC) begin
        acc <= acc - prod_ext;
        k   <= k + 1'b1;
      end
      if (state == ST_OUT) begin
        y_out   <= y_nx;
        y_valid <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_lpc_synth.sv
// Scoreboard bench for lpc_synth: directed filter cases plus randomized samples
// checked against an arithmetic model of y[n] = e[n] - sum a_k*y[n-k].
module tb_lpc_synth;
  localparam int ORDER = 10;

  logic        clk = 1'b0;
  logic        rst, coef_wr, coef_commit, flush, e_valid;
  logic [3:0]  coef_addr;
  logic [15:0] coef_data, e_in;
  logic        e_ready, y_valid;
  logic [15:0] y_out;

  always #5 clk = ~clk;

  lpc_synth #(.ORDER(ORDER), .COEF_FRAC(12)) dut (
    .clk(clk), .rst(rst), .coef_wr(coef_wr), .coef_addr(coef_addr), .coef_data(coef_data),
    .coef_commit(coef_commit), .flush(flush), .e_in(e_in), .e_valid(e_valid),
    .e_ready(e_ready), .y_out(y_out), .y_valid(y_valid)
  );

  typedef struct { int y; int edge_n; string name; } exp_t;
  exp_t sbq[$];
  int   checks = 0, errors = 0, cyc = 0;
  int   shadow_m [ORDER];
  int   act_m    [ORDER];
  int   hist_m[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int model_y(input int e);
    longint a;
    int     yk, r;
    a = longint'(e) * 4096;
    for (int j = 1; j <= ORDER; j++) begin
      yk = (hist_m.size() >= j) ? hist_m[j-1] : 0;
      a  = a - longint'(act_m[j-1]) * longint'(yk);
    end
    a = (a + 2048) >>> 12;
`ifdef LPC_SYNTH_SAT_EN
    if (a > 32767) a = 32767;
    if (a < -32768) a = -32768;
    r = int'(a);
`else
    r = int'(a & 64'hffff);
    if (r > 32767) r -= 65536;
`endif
    return r;
  endfunction

  // Monitor: every y_valid must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (y_valid) begin
      if (sbq.size() == 0) begin
        check("unexpected_y_valid", 1, 0);
      end else begin
        exp_t x;
        x = sbq.pop_front();
        check({x.name, "_value"}, int'($signed(y_out)), x.y);
        check({x.name, "_latency"}, cyc + 1 - x.edge_n, ORDER + 2);
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!e_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!e_ready) check("ready_timeout", int'(e_ready), 1);
  endtask

  task automatic send(input int e, input bit fl, input bit cm, input bit ovr,
                      input int yexp, input string nm);
    int   y;
    exp_t x;
    wait_ready();
    if (fl) hist_m.delete();
    if (cm) act_m = shadow_m;
    y = model_y(e);
    x.y = ovr ? yexp : y;
    x.edge_n = cyc + 1;
    x.name = nm;
    sbq.push_back(x);
    hist_m.push_front(y);
    if (hist_m.size() > ORDER) void'(hist_m.pop_back());
    e_in = 16'(e); e_valid = 1'b1; flush = fl; coef_commit = cm;
    @(negedge clk);
    e_valid = 1'b0; flush = 1'b0; coef_commit = 1'b0;
  endtask

  task automatic wr_coef(input int addr, input int data);
    coef_wr = 1'b1; coef_addr = 4'(addr); coef_data = 16'(data);
    @(negedge clk);
    coef_wr = 1'b0;
    if (addr < ORDER) shadow_m[addr] = data;
  endtask

  task automatic commit_idle();
    wait_ready();
    coef_commit = 1'b1;
    @(negedge clk);
    coef_commit = 1'b0;
    act_m = shadow_m;
  endtask

  task automatic model_reset();
    hist_m.delete();
    sbq.delete();
    for (int i = 0; i < ORDER; i++) begin
      shadow_m[i] = 0;
      act_m[i] = 0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sbq.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain_outstanding", sbq.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; coef_wr = 0; coef_addr = 0; coef_data = 0; coef_commit = 0;
    flush = 0; e_in = 0; e_valid = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_y_valid", int'(y_valid), 0);
    check("rst_y_out", int'(y_out), 0);
    check("rst_e_ready", int'(e_ready), 1);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_e_ready", int'(e_ready), 1);

    // zero coefficients pass the excitation through
    commit_idle();
    send(1000, 0, 0, 1, 1000, "pass1000");
    drain();

    // a1 = -0.5 decaying impulse response
    wr_coef(0, -2048);
    commit_idle();
    send(4096, 1, 0, 1, 4096, "imp0");
    send(0, 0, 0, 1, 2048, "imp1");
    send(0, 0, 0, 1, 1024, "imp2");
    send(0, 0, 0, 1, 512,  "imp3");
    send(0, 0, 0, 1, 256,  "imp4");
    drain();

    // flush coinciding with an accepted sample sees empty history
    send(4096, 1, 0, 1, 4096, "flush_with_valid");
    send(0, 0, 0, 1, 2048, "after_flush");

    // commit during MAC: current sample old bank, next sample new bank
    send(0, 0, 0, 1, 1024, "old_bank");
    wr_coef(0, 4096);
    coef_commit = 1'b1;
    @(negedge clk);
    coef_commit = 1'b0;
    act_m = shadow_m;
    send(0, 0, 0, 1, -1024, "new_bank");

    // commit in IDLE on the acceptance edge applies to that sample
    wr_coef(0, -2048);
    send(0, 0, 1, 1, -512, "commit_with_valid");
    drain();

    // overflow handling
    do_reset();
    wr_coef(0, -4096);
    commit_idle();
    send(20000, 0, 0, 1, 20000, "ovf_first");
`ifdef LPC_SYNTH_SAT_EN
    send(20000, 0, 0, 1, 32767, "ovf_sat");
`else
    send(20000, 0, 0, 1, -25536, "ovf_wrap");
`endif
    drain();

    // reset mid-MAC abandons the sample
    wait_ready();
    e_in = 16'd1000; e_valid = 1'b1;
    @(negedge clk);
    e_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    check("midrst_y_valid", int'(y_valid), 0);
    check("midrst_y_out", int'(y_out), 0);
    check("midrst_e_ready", int'(e_ready), 1);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_e_ready_next", int'(e_ready), 1);
    repeat (14) @(negedge clk);
    send(1000, 0, 0, 1, 1000, "after_midrst");
    drain();

    // randomized coefficients and samples across pointer wrap
    do_reset();
    for (int i = 0; i < ORDER; i++) wr_coef(i, int'($urandom_range(0, 4000)) - 2000);
    for (int i = ORDER; i < 16; i++) wr_coef(i, int'($urandom_range(0, 65535)) - 32768);
    commit_idle();
    for (int n = 0; n < 25; n++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send(int'($urandom_range(0, 40000)) - 20000, 0, 0, 0, 0, "rand");
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/lpc_synth.md
LPC_SYNTH -- requirements
Module: lpc_synth

Interface
REQ-001 SHALL have parameter ORDER, default 10, the predictor order (number of a_k coefficients and history taps).
REQ-002 SHALL have parameter COEF_FRAC, default 12, the coefficient fraction bits (coefficients are signed Q3.12).
REQ-003 clk  in  1  clock; all logic samples on posedge clk.
REQ-004 rst  in  1  reset; synchronous, active-high.
REQ-005 coef_wr  in  1  write coef_data into shadow bank slot coef_addr.
REQ-006 coef_addr  in  4  slot 0..ORDER-1 maps to a1..a_ORDER.
REQ-007 coef_data  in  16  signed Q3.12 coefficient.
REQ-008 coef_commit  in  1  copy shadow bank to active bank.
REQ-009 flush  in  1  clear synthesis history.
REQ-010 e_in  in  16  signed excitation sample.
REQ-011 e_valid  in  1  e_in is valid.
REQ-012 e_ready  out  1  block accepts a sample.
REQ-013 y_out  out  16  signed synthesized sample.
REQ-014 y_valid  out  1  y_out is valid; one-cycle pulse.

Function
REQ-015 SHALL compute y[n] = e[n] - sum(k=1..ORDER) a_k*y[n-k], the all-pole LPC synthesis filter (decoder counterpart of the analysis chain).
REQ-016 SHALL accept a sample on any edge with e_valid=1 and e_ready=1; e_ready SHALL be 1 only in state IDLE.
REQ-017 SHALL use the FSM IDLE -> MAC (ORDER cycles) -> OUT (1 cycle) -> IDLE, with one shared 16x16 signed multiplier.
REQ-018 On acceptance SHALL load a 40-bit signed accumulator with e_in<<<COEF_FRAC.
REQ-019 Each MAC cycle k SHALL subtract a_k*y[n-k], reading history from a ORDER-entry circular buffer indexed from the write pointer.
REQ-020 In OUT SHALL add 2^(COEF_FRAC-1), shift arithmetically right by COEF_FRAC, and reduce to 16 bits per REQ-033/034.
REQ-021 SHALL write the result into the history buffer at the write pointer, then advance the pointer modulo ORDER, wrapping from ORDER-1 to 0.
REQ-022 y_valid SHALL pulse exactly ORDER+2 edges after the acceptance edge; e_ready SHALL reassert in the same cycle.
REQ-023 Throughput SHALL be one sample per ORDER+2 cycles; there is no output backpressure.
REQ-024 coef_wr SHALL be accepted in every state; coef_addr >= ORDER SHALL be ignored.
REQ-025 coef_commit in IDLE SHALL take effect before any sample accepted on the same edge is processed.
REQ-026 coef_commit outside IDLE SHALL be held pending and applied on the OUT->IDLE edge, so a sample never mixes coefficient banks.
REQ-027 flush SHALL be honoured only in IDLE, where it zeroes history and the write pointer; flush outside IDLE SHALL be ignored.
REQ-028 When flush and an accepted sample coincide, that sample SHALL be processed with zero history.

Reset
REQ-029 rst SHALL clear to zero: FSM (to IDLE), accumulator, history, write pointer, both coefficient banks, the pending-commit flag, y_out, and y_valid.
REQ-030 e_ready SHALL be 1 in the first cycle after reset.
REQ-031 rst during MAC or OUT SHALL abandon the sample, produce no y_valid, and leave history unmodified by that sample.
REQ-032 rst SHALL take priority over all other inputs.

Configuration
REQ-033 With LPC_SYNTH_SAT_EN defined, the result SHALL saturate to [-32768, 32767] before output and history write.
REQ-034 Without LPC_SYNTH_SAT_EN, the result SHALL be truncated to its low 16 bits (two's-complement wrap).

Structure
REQ-035 Package lpc_pkg SHALL hold the ORDER and COEF_FRAC defaults, the accumulator width (40), and the FSM state enum.
REQ-036 The circular history buffer and its pointer SHALL be a sub-module lpc_hist_ring (write, flush, indexed read).

Verification
REQ-037 All coefficients 0, commit, e_in=1000 -> y_out=1000, with y_valid exactly 12 edges after acceptance.
REQ-038 a1=-2048 (-0.5), others 0, impulse 4096 then zeros -> y_out = 4096, 2048, 1024, 512, 256.
REQ-039 a1=-4096 (-1.0), e_in=20000 twice -> second y_out = 32767 with LPC_SYNTH_SAT_EN, -25536 without.
REQ-040 Issue a commit of new a1 during MAC -> current sample uses the old bank and the next sample uses the new bank; also check flush together with e_valid in IDLE gives the zero-history result.
REQ-041 Assert rst at MAC cycle 5 -> no y_valid, all outputs 0, e_ready=1 next cycle, and a following impulse reproduces the REQ-037 result.
REQ-042 Run 25 samples with ORDER=10 and random coefficients -> bit-exact against a reference model across pointer wrap-around.
